fp_dot_accum: RTL

FP_DOT_ACCUM -- requirements
Module: fp_dot_accum

---
 rtl/fp_pkg.sv | 31 +++
 rtl/fp_dot_accum_fifo.sv | 55 +++++
 rtl/fp_dot_accum.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared FP32 field widths, special encodings and FSM state type for the dot-product accumulator.
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MAN_W  = 24;
  localparam int BIAS   = 127;

  localparam logic [31:0] QNAN       = 32'hFFFF_FFFF;
  localparam logic [31:0] POS_INF    = 32'h7F80_0000;
  localparam logic [31:0] MAX_FINITE = 32'h7F7F_FFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ALIGN,
    S_ADD,
    S_NORM
  } state_t;

  // Leading-zero count of a 27-bit working mantissa; 27 when all zero.
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) n = 5'(26 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/fp_dot_accum_fifo.sv
// Synchronous product FIFO with full/empty and simultaneous push/pop; a push while full is
// only taken when a pop frees a slot in the same cycle.
module fp_dot_accum_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 35
) (
  input  logic             CLK,
  input  logic             NRST,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fp_dot_accum.sv
// FP32 dot-product accumulator: buffers multiplier products and sums them in a 4-cycle pipeline.
// Define FPACC_SATURATE_EN to saturate rounding overflow to max finite instead of INF.
//
// state | meaning
// IDLE  | waiting for START
// LOAD  | pop and unpack next product when FIFO non-empty
// ALIGN | order operands by magnitude, shift smaller with guard/round/sticky
// ADD   | add or subtract aligned mantissas
// NORM  | normalise, round to nearest even, update accumulator
module fp_dot_accum
  import fp_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 8
) (
  input  logic             CLK,
  input  logic             NRST,
  input  logic             START,
  input  logic [LEN_W-1:0] VEC_LEN,
  input  logic             DI_VALID,
  input  logic [31:0]      DIN,
  input  logic             DIN_NAN,
  input  logic             DIN_INF,
  input  logic             DIN_OVF,
  output logic             BUSY,
  output logic             DO_VALID,
  output logic [31:0]      SUM,
  output logic             NaN,
  output logic             INF,
  output logic             overflow,
  output logic             FIFO_OVF
);

  state_t state, state_nxt;
  logic [LEN_W-1:0] len_q, cnt_q;
  logic start_acc, push_req, pop_req, fifo_clr, fifo_full, fifo_empty, last;
  logic [34:0] fifo_rdata;

  assign start_acc = START && (state == S_IDLE);
  assign push_req  = DI_VALID && ((state != S_IDLE) || start_acc);
  assign pop_req   = (state == S_LOAD) && !fifo_empty;
  assign fifo_clr  = (state == S_IDLE) && !START;
  assign last      = ((cnt_q + LEN_W'(1)) == len_q);
  assign BUSY      = (state != S_IDLE);

  fp_dot_accum_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(35)) u_fifo (
    .CLK   (CLK),
    .NRST  (NRST),
    .clr   (fifo_clr),
    .push  (push_req),
    .pop   (pop_req),
    .wdata ({DIN_OVF, DIN_INF, DIN_NAN, DIN}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (START) state_nxt = (VEC_LEN == '0) ? S_IDLE : S_LOAD;
      S_LOAD:  if (!fifo_empty) state_nxt = S_ALIGN;
      S_ALIGN: state_nxt = S_ADD;
      S_ADD:   state_nxt = S_NORM;
      S_NORM:  state_nxt = last ? S_IDLE : S_LOAD;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Unpacked product; exponent-0 inputs collapse to signed zero.
  logic        b_sign, b_nan, b_inf, b_ovf;
  logic [7:0]  b_exp, f_exp;
  logic [23:0] b_man;
  assign f_exp = fifo_rdata[30:23];

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      {b_sign, b_nan, b_inf, b_ovf} <= '0;
      b_exp <= '0;
      b_man <= '0;
    end else if (pop_req) begin
      b_sign <= fifo_rdata[31];
      b_nan  <= fifo_rdata[32] || (f_exp == 8'hFF && fifo_rdata[22:0] != '0);
      b_inf  <= fifo_rdata[33] || fifo_rdata[34] || (f_exp == 8'hFF && fifo_rdata[22:0] == '0);
      b_ovf  <= fifo_rdata[34];
      b_exp  <= f_exp;
      b_man  <= (f_exp == '0) ? '0 : {1'b1, fifo_rdata[22:0]};
    end
  end

  logic [31:0] acc;
  logic        acc_nan, acc_inf, acc_ovf;
  logic [7:0]  a_exp, big_e, sml_e, dexp, big_e_q;
  logic [23:0] a_man, big_m, sml_m, big_m_q;
  logic [50:0] ext;
  logic [26:0] sml_m27, sml_m27_q;
  logic        b_big, big_s_q, eff_sub_q;

  always_comb begin
    a_exp   = acc[30:23];
    a_man   = (a_exp == '0) ? '0 : {1'b1, acc[22:0]};
    b_big   = {b_exp, b_man} > {a_exp, a_man};
    big_e   = b_big ? b_exp : a_exp;
    sml_e   = b_big ? a_exp : b_exp;
    big_m   = b_big ? b_man : a_man;
    sml_m   = b_big ? a_man : b_man;
    dexp    = big_e - sml_e;
    ext     = {sml_m, 27'b0} >> dexp;
    sml_m27 = (dexp > 8'd25) ? {26'b0, |sml_m} : {ext[50:25], |ext[24:0]};
  end

  logic [27:0] sum_r;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      big_s_q   <= 1'b0;
      eff_sub_q <= 1'b0;
      big_e_q   <= '0;
      big_m_q   <= '0;
      sml_m27_q <= '0;
      sum_r     <= '0;
    end else begin
      if (state == S_ALIGN) begin
        big_s_q   <= b_big ? b_sign : acc[31];
        eff_sub_q <= acc[31] ^ b_sign;
        big_e_q   <= big_e;
        big_m_q   <= big_m;
        sml_m27_q <= sml_m27;
      end
      if (state == S_ADD) begin
        sum_r <= eff_sub_q ? ({1'b0, big_m_q, 3'b000} - {1'b0, sml_m27_q})
                           : ({1'b0, big_m_q, 3'b000} + {1'b0, sml_m27_q});
      end
    end
  end

  logic [4:0]         lz;
  logic [26:0]        nm;
  logic signed [9:0]  ne, re;
  logic [24:0]        rm;
  logic [22:0]        frac;
  logic               rnd, fin_ovf;
  logic [31:0]        fin, acc_nxt;
  logic               nan_nxt, inf_nxt, ovf_nxt;

  always_comb begin
    lz = lzc27(sum_r[26:0]);
    if (sum_r[27]) begin
      nm = {sum_r[27:2], |sum_r[1:0]};
      ne = $signed({2'b0, big_e_q}) + 10'sd1;
    end else begin
      nm = sum_r[26:0] << lz;
      ne = $signed({2'b0, big_e_q}) - $signed({5'b0, lz});
    end
    rnd  = nm[2] & (nm[3] | (|nm[1:0]));
    rm   = {1'b0, nm[26:3]} + {24'b0, rnd};
    re   = rm[24] ? ne + 10'sd1 : ne;
    frac = rm[24] ? rm[23:1] : rm[22:0];
    fin_ovf = 1'b0;
    if (sum_r == '0 || re < 10'sd1) begin
      fin = '0;
    end else if (re > 10'sd254) begin
      fin     = {big_s_q, POS_INF[30:0]};
      fin_ovf = 1'b1;
    end else begin
      fin = {big_s_q, re[7:0], frac};
    end

    acc_nxt = fin;
    nan_nxt = acc_nan;
    inf_nxt = acc_inf;
    ovf_nxt = acc_ovf | b_ovf;
    if (acc_nan || b_nan || (acc_inf && b_inf && (acc[31] != b_sign))) begin
      acc_nxt = QNAN;
      nan_nxt = 1'b1;
      inf_nxt = 1'b0;
    end else if (acc_inf) begin
      acc_nxt = acc;
    end else if (b_inf) begin
      acc_nxt = {b_sign, POS_INF[30:0]};
      inf_nxt = 1'b1;
    end else if (fin_ovf) begin
      ovf_nxt = 1'b1;
`ifdef FPACC_SATURATE_EN
      acc_nxt = {big_s_q, MAX_FINITE[30:0]};
`else
      inf_nxt = 1'b1;
`endif
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      acc      <= '0;
      {acc_nan, acc_inf, acc_ovf} <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      DO_VALID <= 1'b0;
      SUM      <= '0;
      {NaN, INF, overflow} <= '0;
      FIFO_OVF <= 1'b0;
    end else begin
      DO_VALID <= 1'b0;
      if (start_acc) begin
        acc   <= '0;
        {acc_nan, acc_inf, acc_ovf} <= '0;
        len_q <= VEC_LEN;
        cnt_q <= '0;
      end else if (state == S_NORM) begin
        acc   <= acc_nxt;
        {acc_nan, acc_inf, acc_ovf} <= {nan_nxt, inf_nxt, ovf_nxt};
        cnt_q <= cnt_q + LEN_W'(1);
      end
      if (start_acc && VEC_LEN == '0) begin
        DO_VALID <= 1'b1;
        SUM      <= '0;
        {NaN, INF, overflow} <= '0;
      end else if (state == S_NORM && last) begin
        DO_VALID <= 1'b1;
        SUM      <= acc_nxt;
        {NaN, INF, overflow} <= {nan_nxt, inf_nxt, ovf_nxt};
      end
      if (start_acc)                                  FIFO_OVF <= 1'b0;
      else if (push_req && fifo_full && !pop_req)     FIFO_OVF <= 1'b1;
    end
  end

endmodule
